line_win_scanner: RTL

//  Parametrised win detector for the connect-four core. Runs once per dropped piece.

---
 rtl/connect_four_pkg.sv | 47 ++++
 rtl/line_win_scanner_cell_stepper.sv | 29 ++
 rtl/line_win_scanner.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/connect_four_pkg.sv
// Shared types for the connect-four core: piece codes, scan axes with their
// step deltas, and the win-scanner state encoding.
package connect_four_pkg;

    localparam int unsigned PIECE_EMPTY = 0;
    localparam int unsigned PIECE_P1    = 1;
    localparam int unsigned PIECE_P2    = 2;

    typedef enum logic [1:0] {
        AXIS_HORIZ = 2'd0,
        AXIS_VERT  = 2'd1,
        AXIS_DIAG  = 2'd2,
        AXIS_ANTI  = 2'd3
    } axis_t;

    typedef struct packed {
        logic signed [1:0] dr;
        logic signed [1:0] dc;
    } delta_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ORIGIN    = 3'd1,
        ST_SCAN_POS  = 3'd2,
        ST_SCAN_NEG  = 3'd3,
        ST_AXIS_EVAL = 3'd4,
        ST_MARK      = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Unit step along an axis; neg selects the opposite direction.
    function automatic delta_t axis_delta(input axis_t axis, input logic neg);
        delta_t d;
        case (axis)
            AXIS_HORIZ: d = '{dr: 2'sd0, dc: 2'sd1};
            AXIS_VERT:  d = '{dr: 2'sd1, dc: 2'sd0};
            AXIS_DIAG:  d = '{dr: 2'sd1, dc: 2'sd1};
            default:    d = '{dr: 2'sd1, dc: -2'sd1};
        endcase
        if (neg) begin
            d.dr = -d.dr;
            d.dc = -d.dc;
        end
        return d;
    endfunction

endpackage

// File: rtl/line_win_scanner_cell_stepper.sv
// Combinational board-coordinate step: coord + signed unit delta, with an
// in-bounds flag computed on the widened signed value before truncation.
module cell_stepper #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned ROW_W = 3,
    parameter int unsigned COL_W = 3
) (
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    input  logic signed [1:0] i_dr,
    input  logic signed [1:0] i_dc,
    output logic [ROW_W-1:0]  o_row,
    output logic [COL_W-1:0]  o_col,
    output logic              o_in_bounds
);

    logic signed [ROW_W:0] w_row_s;
    logic signed [COL_W:0] w_col_s;

    assign w_row_s = $signed({1'b0, i_row}) + (ROW_W+1)'(i_dr);
    assign w_col_s = $signed({1'b0, i_col}) + (COL_W+1)'(i_dc);

    assign o_in_bounds = !w_row_s[ROW_W] && ($unsigned(w_row_s) < (ROW_W+1)'(ROWS))
                      && !w_col_s[COL_W] && ($unsigned(w_col_s) < (COL_W+1)'(COLS));
    assign o_row = w_row_s[ROW_W-1:0];
    assign o_col = w_col_s[COL_W-1:0];

endmodule

// File: rtl/line_win_scanner.sv
// Connect-four win detector: measures the run through a newly dropped piece on
// four axes (one board read per cycle) and streams the winning run for marking.
module line_win_scanner
    import connect_four_pkg::*;
#(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned WIN_LEN = 4,
    parameter int unsigned PIECE_W = 2,
    parameter int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ROW_W-1:0]   row,
    input  logic [COL_W-1:0]   col,
    output logic               busy,
    output logic [ROW_W-1:0]   read_row,
    output logic [COL_W-1:0]   read_col,
    input  logic [PIECE_W-1:0] data_in,
    output logic               finished_checking,
    output logic [PIECE_W-1:0] winner,
    output logic               w_winning_pieces,
    output logic [ROW_W-1:0]   winning_row,
    output logic [COL_W-1:0]   winning_col
);

    localparam int unsigned CNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam int unsigned TOT_W = $clog2(2 * WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIN_LEN - 1);

    state_t             r_state, w_state_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_fin, w_fin_nxt;
    logic [PIECE_W-1:0] r_winner, w_winner_nxt;
    logic [PIECE_W-1:0] r_piece, w_piece_nxt;
    axis_t              r_axis, w_axis_nxt;
    logic [CNT_W-1:0]   r_pos, w_pos_nxt, r_neg, w_neg_nxt;
    logic [ROW_W-1:0]   r_rd_row, w_rd_row_nxt, r_mk_row, w_mk_row_nxt;
    logic [COL_W-1:0]   r_rd_col, w_rd_col_nxt, r_mk_col, w_mk_col_nxt;
    logic               r_strb, w_strb_nxt;
    logic [TOT_W-1:0]   r_mk_left, w_mk_left_nxt;

    axis_t            w_axis_sel;
    delta_t           w_dlt_step, w_dlt_op, w_dlt_on, w_dlt_mk;
    logic [ROW_W-1:0] w_rd_nrow, w_op_row, w_on_row, w_mk_nrow, w_start_row, w_mk0_row;
    logic [COL_W-1:0] w_rd_ncol, w_op_col, w_on_col, w_mk_ncol, w_start_col, w_mk0_col;
    logic             w_rd_ok, w_op_ok, w_on_ok, w_mk_ok;
    logic             w_accept, w_coord_ok, w_org_empty, w_match, w_cont, w_win;
    logic [CNT_W-1:0] w_cnt_cur, w_cnt_inc;
    logic [TOT_W-1:0] w_total;

    // Axis whose direction starts are needed this cycle (next axis while evaluating).
    always_comb begin
        case (r_state)
            ST_ORIGIN:    w_axis_sel = AXIS_HORIZ;
            ST_AXIS_EVAL: w_axis_sel = axis_t'(r_axis + 2'd1);
            default:      w_axis_sel = r_axis;
        endcase
    end

    assign w_dlt_step = axis_delta(r_axis, r_state == ST_SCAN_NEG);
    assign w_dlt_op   = axis_delta(w_axis_sel, 1'b0);
    assign w_dlt_on   = axis_delta(w_axis_sel, 1'b1);
    assign w_dlt_mk   = axis_delta(r_axis, 1'b0);

    cell_stepper #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_step_rd (
        .i_row(r_rd_row), .i_col(r_rd_col), .i_dr(w_dlt_step.dr), .i_dc(w_dlt_step.dc),
        .o_row(w_rd_nrow), .o_col(w_rd_ncol), .o_in_bounds(w_rd_ok)
    );
    cell_stepper #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_step_op (
        .i_row(row), .i_col(col), .i_dr(w_dlt_op.dr), .i_dc(w_dlt_op.dc),
        .o_row(w_op_row), .o_col(w_op_col), .o_in_bounds(w_op_ok)
    );
    cell_stepper #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_step_on (
        .i_row(row), .i_col(col), .i_dr(w_dlt_on.dr), .i_dc(w_dlt_on.dc),
        .o_row(w_on_row), .o_col(w_on_col), .o_in_bounds(w_on_ok)
    );
    cell_stepper #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_step_mk (
        .i_row(r_mk_row), .i_col(r_mk_col), .i_dr(w_dlt_mk.dr), .i_dc(w_dlt_mk.dc),
        .o_row(w_mk_nrow), .o_col(w_mk_ncol), .o_in_bounds(w_mk_ok)
    );

    assign w_accept    = start && !r_fin;
    assign w_coord_ok  = ({1'b0, row} < (ROW_W+1)'(ROWS)) && ({1'b0, col} < (COL_W+1)'(COLS));
    assign w_org_empty = (data_in == PIECE_W'(PIECE_EMPTY));
    assign w_match     = (data_in == r_piece);
    assign w_cnt_cur   = (r_state == ST_SCAN_NEG) ? r_neg : r_pos;
    assign w_cnt_inc   = (w_cnt_cur == CNT_MAX) ? CNT_MAX : w_cnt_cur + CNT_W'(1);
    assign w_cont      = w_match && (w_cnt_inc < CNT_MAX) && w_rd_ok;
    assign w_total     = TOT_W'(r_pos) + TOT_W'(r_neg) + TOT_W'(1);
    assign w_win       = (w_total >= TOT_W'(WIN_LEN));

    // First read of a direction: + start if in bounds, else - start, else hold.
    assign w_start_row = w_op_ok ? w_op_row : (w_on_ok ? w_on_row : r_rd_row);
    assign w_start_col = w_op_ok ? w_op_col : (w_on_ok ? w_on_col : r_rd_col);

    // The - end of the run; positive axis deltas always have dr in {0,+1}.
    assign w_mk0_row = (w_dlt_mk.dr == 2'sd1) ? row - ROW_W'(r_neg) : row;
    assign w_mk0_col = (w_dlt_mk.dc == 2'sd1)  ? col - COL_W'(r_neg) :
                       (w_dlt_mk.dc == -2'sd1) ? col + COL_W'(r_neg) : col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept) w_state_nxt = w_coord_ok ? ST_ORIGIN : ST_DONE;
            ST_ORIGIN: begin
                if (w_org_empty) w_state_nxt = ST_DONE;
                else if (w_op_ok) w_state_nxt = ST_SCAN_POS;
                else if (w_on_ok) w_state_nxt = ST_SCAN_NEG;
                else              w_state_nxt = ST_AXIS_EVAL;
            end
            ST_SCAN_POS:  if (!w_cont) w_state_nxt = w_on_ok ? ST_SCAN_NEG : ST_AXIS_EVAL;
            ST_SCAN_NEG:  if (!w_cont) w_state_nxt = ST_AXIS_EVAL;
            ST_AXIS_EVAL: begin
                if (w_win)                    w_state_nxt = ST_MARK;
                else if (r_axis == AXIS_ANTI) w_state_nxt = ST_DONE;
                else if (w_op_ok)             w_state_nxt = ST_SCAN_POS;
                else if (w_on_ok)             w_state_nxt = ST_SCAN_NEG;
                else                          w_state_nxt = ST_AXIS_EVAL;
            end
            ST_MARK:      if (r_mk_left == '0) w_state_nxt = ST_DONE;
            ST_DONE:      w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt    = r_busy;
        w_fin_nxt     = 1'b0;
        w_winner_nxt  = r_winner;
        w_piece_nxt   = r_piece;
        w_axis_nxt    = r_axis;
        w_pos_nxt     = r_pos;
        w_neg_nxt     = r_neg;
        w_rd_row_nxt  = r_rd_row;
        w_rd_col_nxt  = r_rd_col;
        w_strb_nxt    = 1'b0;
        w_mk_row_nxt  = r_mk_row;
        w_mk_col_nxt  = r_mk_col;
        w_mk_left_nxt = r_mk_left;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                w_rd_row_nxt = row;
                w_rd_col_nxt = col;
                w_busy_nxt   = 1'b1;
                w_winner_nxt = '0;
            end
            ST_ORIGIN: begin
                w_piece_nxt = data_in;
                w_axis_nxt  = AXIS_HORIZ;
                w_pos_nxt   = '0;
                w_neg_nxt   = '0;
                if (!w_org_empty) begin
                    w_rd_row_nxt = w_start_row;
                    w_rd_col_nxt = w_start_col;
                end
            end
            ST_SCAN_POS: begin
                if (w_match) w_pos_nxt = w_cnt_inc;
                if (w_cont) begin
                    w_rd_row_nxt = w_rd_nrow;
                    w_rd_col_nxt = w_rd_ncol;
                end else if (w_on_ok) begin
                    w_rd_row_nxt = w_on_row;
                    w_rd_col_nxt = w_on_col;
                end
            end
            ST_SCAN_NEG: begin
                if (w_match) w_neg_nxt = w_cnt_inc;
                if (w_cont) begin
                    w_rd_row_nxt = w_rd_nrow;
                    w_rd_col_nxt = w_rd_ncol;
                end
            end
            ST_AXIS_EVAL: begin
                if (w_win) begin
                    w_winner_nxt  = r_piece;
                    w_strb_nxt    = 1'b1;
                    w_mk_row_nxt  = w_mk0_row;
                    w_mk_col_nxt  = w_mk0_col;
                    w_mk_left_nxt = w_total - TOT_W'(1);
                end else if (r_axis != AXIS_ANTI) begin
                    w_axis_nxt   = w_axis_sel;
                    w_pos_nxt    = '0;
                    w_neg_nxt    = '0;
                    w_rd_row_nxt = w_start_row;
                    w_rd_col_nxt = w_start_col;
                end
            end
            ST_MARK: if (r_mk_left != '0) begin
                w_strb_nxt    = 1'b1;
                w_mk_left_nxt = r_mk_left - TOT_W'(1);
                if (w_mk_ok) begin
                    w_mk_row_nxt = w_mk_nrow;
                    w_mk_col_nxt = w_mk_ncol;
                end
            end
            ST_DONE: begin
                w_fin_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_fin     <= 1'b0;
            r_winner  <= '0;
            r_piece   <= '0;
            r_axis    <= AXIS_HORIZ;
            r_pos     <= '0;
            r_neg     <= '0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
            r_strb    <= 1'b0;
            r_mk_row  <= '0;
            r_mk_col  <= '0;
            r_mk_left <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_fin     <= w_fin_nxt;
            r_winner  <= w_winner_nxt;
            r_piece   <= w_piece_nxt;
            r_axis    <= w_axis_nxt;
            r_pos     <= w_pos_nxt;
            r_neg     <= w_neg_nxt;
            r_rd_row  <= w_rd_row_nxt;
            r_rd_col  <= w_rd_col_nxt;
            r_strb    <= w_strb_nxt;
            r_mk_row  <= w_mk_row_nxt;
            r_mk_col  <= w_mk_col_nxt;
            r_mk_left <= w_mk_left_nxt;
        end
    end

    assign busy              = r_busy;
    assign read_row          = r_rd_row;
    assign read_col          = r_rd_col;
    assign finished_checking = r_fin;
    assign winner            = r_winner;
    assign w_winning_pieces  = r_strb;
    assign winning_row       = r_mk_row;
    assign winning_col       = r_mk_col;

endmodule
